// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg: state encoding and default sizing for the write arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_BURST_LEN  = 4;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick: combinational round-robin picker, first request after last owner
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_owner_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IW-1:0]    pick_idx_o
);

  logic found;
  int   idx;

  // Offset N_REQ wraps back to last_owner itself, so a lone requester can win again.
  always_comb begin
    pick_o     = '0;
    pick_idx_o = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_owner_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        pick_idx_o  = IW'(idx);
        pick_o[idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_wr_arbiter: round-robin burst arbiter driving an external FIFO write port
// Rev 1.0
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [N_REQ-1:0]            ack_o,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        fifo_enq_o,
  output logic [DATA_WIDTH-1:0]       fifo_data_o,
  input  logic                        rd_req_i,
  output logic                        fifo_deq_o,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        full_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [LW-1:0]    level_q, level_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             enq;
  logic             deq;
  logic             full;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i        (req_i),
    .last_owner_i (last_q),
    .pick_o       (pick),
    .pick_idx_o   (pick_idx)
  );

  // One slot of the FIFO is sacrificed, so "full" is one below DEPTH.
  assign full = (level_q == LW'(DEPTH - 1));
  assign enq  = !rst && (state_q == BURST) && req_i[owner_q] && !full;
  assign deq  = !rst && rd_req_i && (level_q != '0);

  assign ack_o       = enq ? grant_q : '0;
  assign grant_o     = grant_q;
  assign fifo_enq_o  = enq;
  assign fifo_deq_o  = deq;
  assign fifo_data_o = wdata_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
  assign level_o     = level_q;
  assign full_o      = full;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if ((|req_i) && !full) begin
          state_d = BURST;
          grant_d = pick;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (enq) begin
          beat_d = beat_q + 1'b1;
        end
        // A full stall keeps the grant; a dropped request or last beat releases it.
        if (!req_i[owner_q] || (enq && (beat_q == BW'(BURST_LEN - 1)))) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({enq, deq})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      beat_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      level_q <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter: randomized bench against a transaction-level arbiter model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int BL    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req;
  logic [N_REQ*DW-1:0]   wdata;
  logic [N_REQ-1:0]      ack;
  logic [N_REQ-1:0]      grant;
  logic                  fifo_enq;
  logic [DW-1:0]         fifo_data;
  logic                  rd_req;
  logic                  fifo_deq;
  logic [LW-1:0]         level;
  logic                  full;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .BURST_LEN  (BL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .wdata_i     (wdata),
    .ack_o       (ack),
    .grant_o     (grant),
    .fifo_enq_o  (fifo_enq),
    .fifo_data_o (fifo_data),
    .rd_req_i    (rd_req),
    .fifo_deq_o  (fifo_deq),
    .level_o     (level),
    .full_o      (full)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how many beats taken, how full the FIFO is.
  bit m_busy;
  int m_owner, m_beats, m_last, m_level;
  logic [N_REQ-1:0] obs_ack;
  logic [DW-1:0]    obs_data;

  int hold_pct, raise_pct, rd_pct, rst_pm;
  logic [DW-1:0] dat [N_REQ];

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_level = 0;
    m_last  = N_REQ - 1;
  endtask

  task automatic step(output logic [N_REQ-1:0] ackv);
    bit e_full, e_enq, e_deq;
    logic [N_REQ-1:0] e_ack, e_grant;
    #2;
    e_full  = (m_level == DEPTH - 1);
    e_enq   = !rst && m_busy && req[m_owner] && !e_full;
    e_ack   = e_enq ? (N_REQ'(1) << m_owner) : '0;
    e_deq   = !rst && rd_req && (m_level != 0);
    e_grant = m_busy ? (N_REQ'(1) << m_owner) : '0;
    check("grant", 32'(grant), 32'(e_grant));
    check("ack", 32'(ack), 32'(e_ack));
    check("fifo_enq", 32'(fifo_enq), 32'(e_enq));
    check("fifo_deq", 32'(fifo_deq), 32'(e_deq));
    check("level", 32'(level), 32'(m_level));
    check("full", 32'(full), 32'(e_full));
    if (e_enq) check("fifo_data", 32'(fifo_data), 32'(wdata[m_owner*DW +: DW]));
    obs_ack  = ack;
    obs_data = fifo_data;
    ackv     = e_ack;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_level += int'(e_enq) - int'(e_deq);
      if (!m_busy) begin
        if (req != '0 && !e_full) begin
          for (int k = 1; k <= N_REQ; k++) begin
            int c;
            c = (m_last + k) % N_REQ;
            if (req[c]) begin
              m_owner = c;
              break;
            end
          end
          m_busy  = 1'b1;
          m_beats = 0;
        end
      end else begin
        if (e_enq) m_beats++;
        if (m_beats == BL || !req[m_owner]) begin
          m_last = m_owner;
          m_busy = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [N_REQ-1:0] ackv);
    for (int i = 0; i < N_REQ; i++) begin
      if (ackv[i]) begin
        dat[i] = 8'($urandom);
        req[i] = ($urandom_range(99) < hold_pct);
      end else if (!req[i]) begin
        req[i] = ($urandom_range(99) < raise_pct);
      end
      wdata[i*DW +: DW] = dat[i];
    end
    rd_req = ($urandom_range(99) < rd_pct);
    rst    = ($urandom_range(999) < rst_pm);
  endtask

  initial begin
    logic [N_REQ-1:0] a;
    int nack;
    int ack_cyc [6];
    logic [DW-1:0] got [6];
    int exp_cyc [6] = '{1, 2, 3, 4, 6, 7};
    int rd_tab [6]  = '{10, 90, 50, 30, 70, 50};

    rst = 1'b1; req = '0; rd_req = 1'b0; wdata = '0;
    for (int i = 0; i < N_REQ; i++) dat[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    step(a);
    rst = 1'b0;

    // Single requester, six beats: a full burst, one idle cycle, then two more.
    nack = 0;
    req = 4'b0001;
    wdata[DW-1:0] = 8'hA1;
    for (int c = 0; c < 12; c++) begin
      step(a);
      if (obs_ack[0] && nack < 6) begin
        ack_cyc[nack] = c;
        got[nack]     = obs_data;
        nack++;
        if (nack == 6) req = '0;
        else wdata[DW-1:0] = 8'(8'hA1 + nack);
      end
    end
    check("single_ack_count", 32'(nack), 32'd6);
    for (int k = 0; k < 6; k++) begin
      check("single_ack_cycle", 32'(ack_cyc[k]), 32'(exp_cyc[k]));
      check("single_data", 32'(got[k]), 32'(8'hA1 + k));
    end

    // Fill with no reads, then a single read.
    hold_pct = 100; raise_pct = 100; rd_pct = 0; rst_pm = 0;
    for (int i = 0; i < N_REQ; i++) dat[i] = 8'($urandom);
    drive('0);
    for (int c = 0; c < 40; c++) begin
      step(a);
      drive(a);
    end
    check("fill_level", 32'(level), 32'(DEPTH - 1));
    check("fill_full", 32'(full), 32'd1);
    check("fill_stall_ack", 32'(ack), 32'd0);
    rd_req = 1'b1;
    step(a);
    rd_req = 1'b0;
    step(a);

    // Randomized traffic with occasional resets and varying drain rates.
    hold_pct = 70; raise_pct = 40; rst_pm = 3;
    for (int b = 0; b < 6; b++) begin
      rd_pct = rd_tab[b];
      for (int c = 0; c < 400; c++) begin
        step(a);
        drive(a);
      end
    end

    // Reset in the middle of a burst.
    rst = 1'b0; rst_pm = 0; rd_pct = 0; hold_pct = 100; raise_pct = 100;
    req = '1;
    for (int c = 0; c < 20 && !(m_busy && m_beats > 0); c++) begin
      step(a);
      drive(a);
    end
    check("pre_rst_busy", 32'(grant != '0), 32'd1);
    rst = 1'b1;
    step(a);
    rst = 1'b0;
    #2;
    check("post_rst_grant", 32'(grant), 32'd0);
    check("post_rst_ack", 32'(ack), 32'd0);
    check("post_rst_level", 32'(level), 32'd0);
    step(a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
